// File: rtl/baccarat_hand_tally.sv
// Card accumulator for NUM_HANDS baccarat hands: one card per load strobe, with
// a running score mod MOD, a card count, and full/natural flags for each hand.
module baccarat_hand_tally #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int CARD_W    = 4,
  parameter int MOD       = 10,
  parameter int HS_W      = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  parameter int SC_W      = $clog2(MOD),
  parameter int CN_W      = $clog2(MAX_CARDS + 1)
) (
  input  logic                      slow_clock,
  input  logic                      resetb,
  input  logic                      clear,
  input  logic                      load,
  input  logic [HS_W-1:0]           hand_sel,
  input  logic [CARD_W-1:0]         card,
  output logic [NUM_HANDS*SC_W-1:0] score,
  output logic [NUM_HANDS*CN_W-1:0] count,
  output logic [NUM_HANDS-1:0]      full,
  output logic [NUM_HANDS-1:0]      natural,
  output logic                      reject
);

  // One extra bit holds score + card value before the single wrap subtraction.
  localparam int SUM_W = SC_W + 1;

  logic [SC_W-1:0]      score_q [NUM_HANDS];
  logic [SC_W-1:0]      score_d [NUM_HANDS];
  logic [CN_W-1:0]      count_q [NUM_HANDS];
  logic [CN_W-1:0]      count_d [NUM_HANDS];
  logic [NUM_HANDS-1:0] natural_q, natural_d;
  logic                 reject_q, reject_d;

  logic                 card_ok;
  logic                 accepted;
  logic [SUM_W-1:0]     value;
  logic [SUM_W-1:0]     sum [NUM_HANDS];

  always_comb begin
    card_ok   = (card != '0) && (card <= CARD_W'(13));
    value     = (card <= CARD_W'(9)) ? SUM_W'(card) : '0;
    score_d   = score_q;
    count_d   = count_q;
    natural_d = natural_q;
    accepted  = 1'b0;
    for (int unsigned i = 0; i < NUM_HANDS; i++) begin
      sum[i] = SUM_W'(score_q[i]) + value;
      if (sum[i] >= SUM_W'(MOD)) begin
        sum[i] = sum[i] - SUM_W'(MOD);
      end
      // An out-of-range hand_sel matches no hand, so it falls through to reject.
      if (load && card_ok && (32'(hand_sel) == i) && (count_q[i] < CN_W'(MAX_CARDS))) begin
        accepted   = 1'b1;
        score_d[i] = sum[i][SC_W-1:0];
        count_d[i] = count_q[i] + 1'b1;
        if ((count_q[i] == CN_W'(1)) &&
            ((sum[i] == SUM_W'(8)) || (sum[i] == SUM_W'(9)))) begin
          natural_d[i] = 1'b1;
        end
      end
    end
    reject_d = load && !accepted;
    if (clear) begin
      score_d   = '{default: '0};
      count_d   = '{default: '0};
      natural_d = '0;
      reject_d  = 1'b0;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      score_q   <= '{default: '0};
      count_q   <= '{default: '0};
      natural_q <= '0;
      reject_q  <= 1'b0;
    end else begin
      score_q   <= score_d;
      count_q   <= count_d;
      natural_q <= natural_d;
      reject_q  <= reject_d;
    end
  end

  for (genvar g = 0; g < NUM_HANDS; g++) begin : g_out
    assign score[g*SC_W +: SC_W] = score_q[g];
    assign count[g*CN_W +: CN_W] = count_q[g];
    assign full[g]               = (count_q[g] == CN_W'(MAX_CARDS));
  end

  assign natural = natural_q;
  assign reject  = reject_q;

endmodule
